// File: rtl/rv_multicycle_ctrl_v2.sv
// ---------------------------------------------------------------------------
// rv_multicycle_ctrl_v2
//   Multicycle RV32I control FSM for the non-pipelined core. Decodes the
//   current state, the IR opcode/func fields and (in BRANCH) the ALU flags
//   into datapath mux selects, the ALU op code and the PC/IR/RF/memory
//   enables. Supports all six conditional branches, JAL/JALR, LUI/AUIPC,
//   loads/stores with an optional memory-ready handshake, a registered
//   retire pulse and an illegal-opcode trap.
//
// Parameters
//   ALUCTL_W      width of alu_control (>=10); bits above 9 are always 0
//   MEM_HANDSHAKE 1: memory states wait for mem_ready; 0: mem_ready ignored
//   ILLEGAL_HALT  1: TRAP is terminal until reset; 0: TRAP returns to FETCH
//
// Ports
//   clk, reset                 clock (rising edge), synchronous active-high reset
//   opcode, func3, func7       instruction fields from IR
//   zero, lt, ltu              ALU flags used by BRANCH
//   mem_ready                  memory access completes this cycle
//   mem_req, mem_write         memory request / store strobe
//   ir_write, pc_write         IR / PC load enables
//   reg_write                  register-file write enable
//   adr_src                    0 = PC, 1 = ALUOut address
//   result_src                 00 ALUOut, 01 mem data, 10 ALU result
//   alu_src_a                  00 PC, 01 oldPC, 10 rs1
//   alu_src_b                  00 rs2, 01 imm, 10 const 4
//   imm_src                    000 I, 001 S, 010 B, 011 J, 100 U
//   alu_control                ALU operation code
//   instr_done                 registered one-cycle pulse per retired instruction
//   illegal                    sticky illegal-opcode flag
//   state_dbg                  current state encoding
// ---------------------------------------------------------------------------
module rv_multicycle_ctrl_v2 #(
  parameter int ALUCTL_W      = 10,
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit ILLEGAL_HALT  = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          opcode,
  input  logic [2:0]          func3,
  input  logic [6:0]          func7,
  input  logic                zero,
  input  logic                lt,
  input  logic                ltu,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                ir_write,
  output logic                mem_write,
  output logic                adr_src,
  output logic                pc_write,
  output logic                reg_write,
  output logic [1:0]          result_src,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [2:0]          imm_src,
  output logic [ALUCTL_W-1:0] alu_control,
  output logic                instr_done,
  output logic                illegal,
  output logic [4:0]          state_dbg
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [9:0] ALU_ADD  = 10'b0000000000;
  localparam logic [9:0] ALU_SUB  = 10'b0100000000;
  localparam logic [9:0] ALU_PASS = 10'b0000001110;

  typedef enum logic [4:0] {
    S_FETCH    = 5'd0,
    S_DECODE   = 5'd1,
    S_MEMADR   = 5'd2,
    S_MEMREAD  = 5'd3,
    S_MEMWB    = 5'd4,
    S_MEMWRITE = 5'd5,
    S_EXEC_R   = 5'd6,
    S_EXEC_I   = 5'd7,
    S_ALUWB    = 5'd8,
    S_BRANCH   = 5'd9,
    S_JAL      = 5'd10,
    S_JALR     = 5'd11,
    S_JALR2    = 5'd12,
    S_AUIPC    = 5'd13,
    S_LUI      = 5'd14,
    S_TRAP     = 5'd15
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic       r_instr_done;
  logic       r_illegal;
  logic       w_retire;
  logic       w_ready;
  logic       w_taken;
  logic [9:0] w_alu;

  assign w_ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

  // Branch condition selected by func3; the reserved encodings never take.
  always_comb begin
    w_taken = 1'b0;
    case (func3)
      3'b000:  w_taken = zero;
      3'b001:  w_taken = ~zero;
      3'b100:  w_taken = lt;
      3'b101:  w_taken = ~lt;
      3'b110:  w_taken = ltu;
      3'b111:  w_taken = ~ltu;
      default: w_taken = 1'b0;
    endcase
  end

  // NOTE: state and flags use non-blocking assignments so every register
  // samples the values computed before this edge, independent of order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_FETCH;
      r_instr_done <= 1'b0;
      r_illegal    <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_instr_done <= w_retire;
      if (w_state_next == S_TRAP) r_illegal <= 1'b1;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so paths that
    // do not mention it cannot infer a latch.
    mem_req      = 1'b0;
    ir_write     = 1'b0;
    mem_write    = 1'b0;
    adr_src      = 1'b0;
    pc_write     = 1'b0;
    reg_write    = 1'b0;
    result_src   = 2'b00;
    alu_src_a    = 2'b00;
    alu_src_b    = 2'b00;
    w_alu        = ALU_ADD;
    w_retire     = 1'b0;
    w_state_next = S_FETCH;

    case (r_state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (w_ready) begin
          ir_write     = 1'b1;
          pc_write     = 1'b1;
          w_state_next = S_DECODE;
        end else begin
          w_state_next = S_FETCH;
        end
      end
      S_DECODE: begin
        // oldPC + imm lands in ALUOut: branch target / AUIPC result.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          OP_LOAD, OP_STORE: w_state_next = S_MEMADR;
          OP_R:              w_state_next = S_EXEC_R;
          OP_IMM:            w_state_next = S_EXEC_I;
          OP_BR:             w_state_next = S_BRANCH;
          OP_JAL:            w_state_next = S_JAL;
          OP_JALR:           w_state_next = S_JALR;
          OP_AUIPC:          w_state_next = S_AUIPC;
          OP_LUI:            w_state_next = S_LUI;
          default:           w_state_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a    = 2'b10;
        alu_src_b    = 2'b01;
        w_state_next = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req      = 1'b1;
        adr_src      = 1'b1;
        w_state_next = w_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src   = 2'b01;
        reg_write    = 1'b1;
        w_retire     = 1'b1;
        w_state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        // Strobe is held with the request for the whole wait.
        mem_req   = 1'b1;
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (w_ready) begin
          w_retire     = 1'b1;
          w_state_next = S_FETCH;
        end else begin
          w_state_next = S_MEMWRITE;
        end
      end
      S_EXEC_R: begin
        alu_src_a    = 2'b10;
        alu_src_b    = 2'b00;
        w_alu        = {func7, func3};
        w_state_next = S_ALUWB;
      end
      S_EXEC_I: begin
        // Only SRAI carries func7[5] into the op code; ADDI etc. ignore it.
        alu_src_a    = 2'b10;
        alu_src_b    = 2'b01;
        w_alu        = {1'b0, func7[5] & (func3 == 3'b101), 5'b00000, func3};
        w_state_next = S_ALUWB;
      end
      S_ALUWB: begin
        result_src   = 2'b00;
        reg_write    = 1'b1;
        w_retire     = 1'b1;
        w_state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b00;
        w_alu      = ALU_SUB;
        result_src = 2'b00;
        pc_write   = w_taken;
        if (func3 == 3'b010 || func3 == 3'b011) begin
          w_state_next = S_TRAP;
        end else begin
          w_retire     = 1'b1;
          w_state_next = S_FETCH;
        end
      end
      S_JAL: begin
        // PC <= ALUOut (target from DECODE) while ALU forms oldPC+4 for rd.
        alu_src_a    = 2'b01;
        alu_src_b    = 2'b10;
        result_src   = 2'b00;
        pc_write     = 1'b1;
        w_state_next = S_ALUWB;
      end
      S_JALR: begin
        alu_src_a    = 2'b10;
        alu_src_b    = 2'b01;
        w_state_next = S_JALR2;
      end
      S_JALR2: begin
        // Target rs1+imm is in ALUOut; the datapath clears its bit 0.
        alu_src_a    = 2'b01;
        alu_src_b    = 2'b10;
        result_src   = 2'b00;
        pc_write     = 1'b1;
        w_state_next = S_ALUWB;
      end
      S_AUIPC: begin
        // Recomputes oldPC+imm so ALUOut is unchanged going into ALUWB.
        alu_src_a    = 2'b01;
        alu_src_b    = 2'b01;
        w_state_next = S_ALUWB;
      end
      S_LUI: begin
        alu_src_a    = 2'b10;
        alu_src_b    = 2'b01;
        w_alu        = ALU_PASS;
        w_state_next = S_ALUWB;
      end
      S_TRAP: begin
        w_state_next = ILLEGAL_HALT ? S_TRAP : S_FETCH;
      end
      default: begin
        w_state_next = S_FETCH;
      end
    endcase

    // Reset silences every strobe in the same cycle, so an aborted
    // instruction can never complete a write.
    if (reset) begin
      mem_req      = 1'b0;
      ir_write     = 1'b0;
      mem_write    = 1'b0;
      adr_src      = 1'b0;
      pc_write     = 1'b0;
      reg_write    = 1'b0;
      result_src   = 2'b00;
      alu_src_a    = 2'b00;
      alu_src_b    = 2'b00;
      w_alu        = ALU_ADD;
      w_retire     = 1'b0;
      w_state_next = S_FETCH;
    end
  end

  // Immediate format depends only on the opcode, in every state.
  always_comb begin
    imm_src = 3'b000;
    if (!reset) begin
      case (opcode)
        OP_STORE:        imm_src = 3'b001;
        OP_BR:           imm_src = 3'b010;
        OP_JAL:          imm_src = 3'b011;
        OP_LUI, OP_AUIPC: imm_src = 3'b100;
        default:         imm_src = 3'b000;
      endcase
    end
  end

  always_comb begin
    alu_control      = '0;
    alu_control[9:0] = w_alu;
  end

  assign instr_done = r_instr_done;
  assign illegal    = r_illegal;
  assign state_dbg  = reset ? 5'd0 : r_state;

endmodule

// File: tb/tb_rv_multicycle_ctrl_v2.sv
module tb_rv_multicycle_ctrl_v2;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_BAD   = 7'b1111111;

  typedef struct packed {
    logic       mem_req;
    logic       ir_write;
    logic       mem_write;
    logic       adr_src;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] imm_src;
    logic [9:0] alu_control;
    logic       instr_done;
    logic       illegal;
    logic [4:0] state_dbg;
  } outv_t;

  typedef struct {
    logic       rst;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       z, l, lu, rdy;
    logic       chk_a, chk_b;
    outv_t      ea, eb;
  } step_t;

  logic       clk;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       zero, lt, ltu, mem_ready;

  logic       mem_req_a, ir_write_a, mem_write_a, adr_src_a, pc_write_a, reg_write_a;
  logic [1:0] result_src_a, alu_src_a_a, alu_src_b_a;
  logic [2:0] imm_src_a;
  logic [9:0] alu_control_a;
  logic       instr_done_a, illegal_a;
  logic [4:0] state_dbg_a;

  logic       mem_req_b, ir_write_b, mem_write_b, adr_src_b, pc_write_b, reg_write_b;
  logic [1:0] result_src_b, alu_src_a_b, alu_src_b_b;
  logic [2:0] imm_src_b;
  logic [9:0] alu_control_b;
  logic       instr_done_b, illegal_b;
  logic [4:0] state_dbg_b;

  int    n_vec = 0;
  int    n_err = 0;
  step_t stp[$];
  outv_t sb_a[$];
  outv_t sb_b[$];

  rv_multicycle_ctrl_v2 #(.ALUCTL_W(10), .MEM_HANDSHAKE(1'b1), .ILLEGAL_HALT(1'b1)) u_dut_halt (
    .clk(clk), .reset(reset), .opcode(opcode), .func3(func3), .func7(func7),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .mem_req(mem_req_a), .ir_write(ir_write_a), .mem_write(mem_write_a),
    .adr_src(adr_src_a), .pc_write(pc_write_a), .reg_write(reg_write_a),
    .result_src(result_src_a), .alu_src_a(alu_src_a_a), .alu_src_b(alu_src_b_a),
    .imm_src(imm_src_a), .alu_control(alu_control_a), .instr_done(instr_done_a),
    .illegal(illegal_a), .state_dbg(state_dbg_a)
  );

  rv_multicycle_ctrl_v2 #(.ALUCTL_W(10), .MEM_HANDSHAKE(1'b1), .ILLEGAL_HALT(1'b0)) u_dut_skip (
    .clk(clk), .reset(reset), .opcode(opcode), .func3(func3), .func7(func7),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .mem_req(mem_req_b), .ir_write(ir_write_b), .mem_write(mem_write_b),
    .adr_src(adr_src_b), .pc_write(pc_write_b), .reg_write(reg_write_b),
    .result_src(result_src_b), .alu_src_a(alu_src_a_b), .alu_src_b(alu_src_b_b),
    .imm_src(imm_src_b), .alu_control(alu_control_b), .instr_done(instr_done_b),
    .illegal(illegal_b), .state_dbg(state_dbg_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic outv_t snap_a();
    return {mem_req_a, ir_write_a, mem_write_a, adr_src_a, pc_write_a, reg_write_a,
            result_src_a, alu_src_a_a, alu_src_b_a, imm_src_a, alu_control_a,
            instr_done_a, illegal_a, state_dbg_a};
  endfunction

  function automatic outv_t snap_b();
    return {mem_req_b, ir_write_b, mem_write_b, adr_src_b, pc_write_b, reg_write_b,
            result_src_b, alu_src_a_b, alu_src_b_b, imm_src_b, alu_control_b,
            instr_done_b, illegal_b, state_dbg_b};
  endfunction

  function automatic outv_t ev(input logic [4:0] st, input logic mreq, irw, mw, adr, pcw, rw,
                               input logic [1:0] rs, sa, sb, input logic [2:0] imm,
                               input logic [9:0] alu, input logic done, ill);
    outv_t v;
    v.mem_req = mreq; v.ir_write = irw; v.mem_write = mw; v.adr_src = adr;
    v.pc_write = pcw; v.reg_write = rw; v.result_src = rs; v.alu_src_a = sa;
    v.alu_src_b = sb; v.imm_src = imm; v.alu_control = alu; v.instr_done = done;
    v.illegal = ill; v.state_dbg = st;
    return v;
  endfunction

  function automatic outv_t e_zero();
    return ev(5'd0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 10'h000, 0, 0);
  endfunction
  function automatic outv_t e_fetch(input logic go, input logic [2:0] imm, input logic done, ill);
    return ev(5'd0, 1, go, 0, 0, go, 0, 2'b10, 2'b00, 2'b10, imm, 10'h000, done, ill);
  endfunction
  function automatic outv_t e_decode(input logic [2:0] imm);
    return ev(5'd1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 10'h000, 0, 0);
  endfunction
  function automatic outv_t e_aluwb(input logic [2:0] imm);
    return ev(5'd8, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, imm, 10'h000, 0, 0);
  endfunction

  function automatic void add(input logic rst, input logic [6:0] op, input logic [2:0] f3,
                              input logic [6:0] f7, input logic z, l, lu, rdy, input outv_t ea);
    step_t s;
    s.rst = rst; s.op = op; s.f3 = f3; s.f7 = f7; s.z = z; s.l = l; s.lu = lu; s.rdy = rdy;
    s.chk_a = 1'b1; s.chk_b = 1'b0; s.ea = ea; s.eb = '0;
    stp.push_back(s);
  endfunction

  // Amend the most recently added step: also check the skip-mode DUT / skip the halt DUT.
  function automatic void also_b(input outv_t eb);
    step_t s;
    s = stp.pop_back();
    s.chk_b = 1'b1; s.eb = eb;
    stp.push_back(s);
  endfunction
  function automatic void no_a();
    step_t s;
    s = stp.pop_back();
    s.chk_a = 1'b0;
    stp.push_back(s);
  endfunction

  // Drive one step mid-cycle and record what each DUT must show for it.
  task automatic apply(input step_t s);
    @(negedge clk);
    reset = s.rst; opcode = s.op; func3 = s.f3; func7 = s.f7;
    zero = s.z; lt = s.l; ltu = s.lu; mem_ready = s.rdy;
    if (s.chk_a) sb_a.push_back(s.ea);
    if (s.chk_b) sb_b.push_back(s.eb);
  endtask

  task automatic test_reset();
    step_t s; outv_t e; int i = 0;
    add(0, OP_LOAD, 3'b010, 7'd0, 0, 0, 0, 1, e_fetch(0, 3'b000, 0, 0));
    stp[0].rst = 1'b1;
    void'(stp.pop_back());
    add(1, OP_LOAD, 3'b010, 7'd0, 0, 0, 0, 1, e_zero());
    add(0, OP_LOAD, 3'b010, 7'd0, 0, 0, 0, 1, e_fetch(1, 3'b000, 0, 0));
    add(0, OP_LOAD, 3'b010, 7'd0, 0, 0, 0, 1, e_decode(3'b000));
    add(0, OP_LOAD, 3'b010, 7'd0, 0, 0, 0, 1, ev(5'd2, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 10'h000, 0, 0));
    add(0, OP_LOAD, 3'b010, 7'd0, 0, 0, 0, 0, ev(5'd3, 1, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 10'h000, 0, 0));
    for (int k = 0; k < 3; k++) add(1, OP_LOAD, 3'b010, 7'd0, 0, 0, 0, 0, e_zero());
    add(0, OP_LOAD, 3'b010, 7'd0, 0, 0, 0, 0, e_fetch(0, 3'b000, 0, 0));
    add(0, OP_LOAD, 3'b010, 7'd0, 0, 0, 0, 1, e_fetch(1, 3'b000, 0, 0));
    add(0, OP_LOAD, 3'b010, 7'd0, 0, 0, 0, 1, e_decode(3'b000));
    add(0, OP_LOAD, 3'b010, 7'd0, 0, 0, 0, 1, ev(5'd2, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 10'h000, 0, 0));
    add(0, OP_LOAD, 3'b010, 7'd0, 0, 0, 0, 1, ev(5'd3, 1, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 10'h000, 0, 0));
    add(0, OP_LOAD, 3'b010, 7'd0, 0, 0, 0, 1, ev(5'd4, 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 10'h000, 0, 0));
    add(0, OP_LOAD, 3'b010, 7'd0, 0, 0, 0, 0, e_fetch(0, 3'b000, 1, 0));
    while (stp.size() > 0) begin
      s = stp.pop_front(); apply(s); #1;
      if (s.chk_a) begin
        e = sb_a.pop_front(); n_vec++;
        if (snap_a() !== e) begin
          n_err++; $display("FAIL reset[%0d]: got %h, required %h", i, snap_a(), e);
        end
      end
      i++;
    end
  endtask

  // R-type, OP-IMM, LUI, AUIPC and JAL: four-cycle ALU-writeback instructions.
  task automatic test_alu_ops();
    step_t s; outv_t e; int i = 0;
    logic [6:0] ops [7]  = '{OP_R, OP_R, OP_IMM, OP_IMM, OP_IMM, OP_LUI, OP_AUIPC};
    logic [2:0] f3s [7]  = '{3'b000, 3'b101, 3'b000, 3'b101, 3'b101, 3'b000, 3'b000};
    logic [6:0] f7s [7]  = '{7'b0100000, 7'b0100000, 7'b0100000, 7'b0100000, 7'b0000000, 7'b0, 7'b0};
    logic [9:0] alus [7] = '{10'h100, 10'h105, 10'h000, 10'h105, 10'h005, 10'h00E, 10'h000};
    logic [4:0] sts [7]  = '{5'd6, 5'd6, 5'd7, 5'd7, 5'd7, 5'd14, 5'd13};
    logic [1:0] sas [7]  = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
    logic [1:0] sbs [7]  = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
    logic [2:0] ims [7]  = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 3'b100};
    for (int k = 0; k < 7; k++) begin
      add(0, ops[k], f3s[k], f7s[k], 0, 0, 0, 1, e_fetch(1, ims[k], 0, 0));
      add(0, ops[k], f3s[k], f7s[k], 0, 0, 0, 1, e_decode(ims[k]));
      add(0, ops[k], f3s[k], f7s[k], 0, 0, 0, 1,
          ev(sts[k], 0, 0, 0, 0, 0, 0, 2'b00, sas[k], sbs[k], ims[k], alus[k], 0, 0));
      add(0, ops[k], f3s[k], f7s[k], 0, 0, 0, 1, e_aluwb(ims[k]));
      add(0, ops[k], f3s[k], f7s[k], 0, 0, 0, 0, e_fetch(0, ims[k], 1, 0));
    end
    add(0, OP_JAL, 3'b000, 7'd0, 0, 0, 0, 1, e_fetch(1, 3'b011, 0, 0));
    add(0, OP_JAL, 3'b000, 7'd0, 0, 0, 0, 1, e_decode(3'b011));
    add(0, OP_JAL, 3'b000, 7'd0, 0, 0, 0, 1, ev(5'd10, 0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 2'b10, 3'b011, 10'h000, 0, 0));
    add(0, OP_JAL, 3'b000, 7'd0, 0, 0, 0, 1, e_aluwb(3'b011));
    add(0, OP_JAL, 3'b000, 7'd0, 0, 0, 0, 0, e_fetch(0, 3'b011, 1, 0));
    while (stp.size() > 0) begin
      s = stp.pop_front(); apply(s); #1;
      if (s.chk_a) begin
        e = sb_a.pop_front(); n_vec++;
        if (snap_a() !== e) begin
          n_err++; $display("FAIL alu_ops[%0d]: got %h, required %h", i, snap_a(), e);
        end
      end
      i++;
    end
  endtask

  task automatic test_mem_wait();
    step_t s; outv_t e; int i = 0;
    outv_t memread = ev(5'd3, 1, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 10'h000, 0, 0);
    outv_t memwr   = ev(5'd5, 1, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b001, 10'h000, 0, 0);
    // Load with two wait states in MEMREAD: 7 cycles to retire.
    add(0, OP_LOAD, 3'b010, 7'd0, 0, 0, 0, 1, e_fetch(1, 3'b000, 0, 0));
    add(0, OP_LOAD, 3'b010, 7'd0, 0, 0, 0, 1, e_decode(3'b000));
    add(0, OP_LOAD, 3'b010, 7'd0, 0, 0, 0, 1, ev(5'd2, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 10'h000, 0, 0));
    add(0, OP_LOAD, 3'b010, 7'd0, 0, 0, 0, 0, memread);
    add(0, OP_LOAD, 3'b010, 7'd0, 0, 0, 0, 0, memread);
    add(0, OP_LOAD, 3'b010, 7'd0, 0, 0, 0, 1, memread);
    add(0, OP_LOAD, 3'b010, 7'd0, 0, 0, 0, 1, ev(5'd4, 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 10'h000, 0, 0));
    add(0, OP_LOAD, 3'b010, 7'd0, 0, 0, 0, 0, e_fetch(0, 3'b000, 1, 0));
    // Store with one wait state: mem_write held together with mem_req.
    add(0, OP_STORE, 3'b010, 7'd0, 0, 0, 0, 1, e_fetch(1, 3'b001, 0, 0));
    add(0, OP_STORE, 3'b010, 7'd0, 0, 0, 0, 1, e_decode(3'b001));
    add(0, OP_STORE, 3'b010, 7'd0, 0, 0, 0, 1, ev(5'd2, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b001, 10'h000, 0, 0));
    add(0, OP_STORE, 3'b010, 7'd0, 0, 0, 0, 0, memwr);
    add(0, OP_STORE, 3'b010, 7'd0, 0, 0, 0, 1, memwr);
    add(0, OP_STORE, 3'b010, 7'd0, 0, 0, 0, 0, e_fetch(0, 3'b001, 1, 0));
    while (stp.size() > 0) begin
      s = stp.pop_front(); apply(s); #1;
      if (s.chk_a) begin
        e = sb_a.pop_front(); n_vec++;
        if (snap_a() !== e) begin
          n_err++; $display("FAIL mem_wait[%0d]: got %h, required %h", i, snap_a(), e);
        end
      end
      i++;
    end
  endtask

  task automatic test_branch();
    step_t s; outv_t e; int i = 0;
    // BNE z=1, BLTU ltu=1, BGE lt=0, BEQ z=1, BLT lt=0
    logic [2:0] f3s [5] = '{3'b001, 3'b110, 3'b101, 3'b000, 3'b100};
    logic       zs  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic       ls  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       lus [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic       tks [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 5; k++) begin
      add(0, OP_BR, f3s[k], 7'd0, zs[k], ls[k], lus[k], 1, e_fetch(1, 3'b010, 0, 0));
      add(0, OP_BR, f3s[k], 7'd0, zs[k], ls[k], lus[k], 1, e_decode(3'b010));
      add(0, OP_BR, f3s[k], 7'd0, zs[k], ls[k], lus[k], 1,
          ev(5'd9, 0, 0, 0, 0, tks[k], 0, 2'b00, 2'b10, 2'b00, 3'b010, 10'h100, 0, 0));
      add(0, OP_BR, f3s[k], 7'd0, zs[k], ls[k], lus[k], 0, e_fetch(0, 3'b010, 1, 0));
    end
    while (stp.size() > 0) begin
      s = stp.pop_front(); apply(s); #1;
      if (s.chk_a) begin
        e = sb_a.pop_front(); n_vec++;
        if (snap_a() !== e) begin
          n_err++; $display("FAIL branch[%0d]: got %h, required %h", i, snap_a(), e);
        end
      end
      i++;
    end
  endtask

  task automatic test_jalr();
    step_t s; outv_t e; int i = 0;
    add(0, OP_JALR, 3'b000, 7'd0, 0, 0, 0, 1, e_fetch(1, 3'b000, 0, 0));
    add(0, OP_JALR, 3'b000, 7'd0, 0, 0, 0, 1, e_decode(3'b000));
    add(0, OP_JALR, 3'b000, 7'd0, 0, 0, 0, 1, ev(5'd11, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 10'h000, 0, 0));
    add(0, OP_JALR, 3'b000, 7'd0, 0, 0, 0, 1, ev(5'd12, 0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 2'b10, 3'b000, 10'h000, 0, 0));
    add(0, OP_JALR, 3'b000, 7'd0, 0, 0, 0, 1, e_aluwb(3'b000));
    add(0, OP_JALR, 3'b000, 7'd0, 0, 0, 0, 0, e_fetch(0, 3'b000, 1, 0));
    while (stp.size() > 0) begin
      s = stp.pop_front(); apply(s); #1;
      if (s.chk_a) begin
        e = sb_a.pop_front(); n_vec++;
        if (snap_a() !== e) begin
          n_err++; $display("FAIL jalr[%0d]: got %h, required %h", i, snap_a(), e);
        end
      end
      i++;
    end
  endtask

  task automatic test_trap();
    step_t s; outv_t e; int i = 0;
    outv_t trap = ev(5'd15, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 10'h000, 0, 1);
    add(0, OP_BAD, 3'b000, 7'd0, 0, 0, 0, 1, e_fetch(1, 3'b000, 0, 0)); also_b(e_fetch(1, 3'b000, 0, 0));
    add(0, OP_BAD, 3'b000, 7'd0, 0, 0, 0, 1, e_decode(3'b000));         also_b(e_decode(3'b000));
    add(0, OP_BAD, 3'b000, 7'd0, 0, 0, 0, 1, trap);                      also_b(trap);
    add(0, OP_BAD, 3'b000, 7'd0, 0, 0, 0, 1, trap);                      also_b(e_fetch(1, 3'b000, 0, 1));
    for (int k = 0; k < 8; k++) add(0, OP_BAD, 3'b000, 7'd0, 0, 0, 0, 1, trap);
    add(1, OP_BAD, 3'b000, 7'd0, 0, 0, 0, 0, e_zero()); no_a();
    add(1, OP_BAD, 3'b000, 7'd0, 0, 0, 0, 0, e_zero()); also_b(e_zero());
    add(0, OP_BAD, 3'b000, 7'd0, 0, 0, 0, 0, e_fetch(0, 3'b000, 0, 0)); also_b(e_fetch(0, 3'b000, 0, 0));
    while (stp.size() > 0) begin
      s = stp.pop_front(); apply(s); #1;
      if (s.chk_a) begin
        e = sb_a.pop_front(); n_vec++;
        if (snap_a() !== e) begin
          n_err++; $display("FAIL trap_halt[%0d]: got %h, required %h", i, snap_a(), e);
        end
      end
      if (s.chk_b) begin
        e = sb_b.pop_front(); n_vec++;
        if (snap_b() !== e) begin
          n_err++; $display("FAIL trap_skip[%0d]: got %h, required %h", i, snap_b(), e);
        end
      end
      i++;
    end
  endtask

  initial begin
    reset = 1'b1; opcode = '0; func3 = '0; func7 = '0;
    zero = 1'b0; lt = 1'b0; ltu = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_alu_ops();
    test_mem_wait();
    test_branch();
    test_jalr();
    test_trap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
